// File: rtl/noc_params.sv
// Shared router parameters and the port encoding.
// The port_t value doubles as the port index.
package noc_params;

  localparam int PORT_NUM  = 5;
  localparam int VC_NUM    = 2;
  localparam int VC_SIZE   = $clog2(VC_NUM);
  localparam int PORT_SIZE = $clog2(PORT_NUM);

  typedef enum logic [PORT_SIZE-1:0] {
    LOCAL,
    NORTH,
    SOUTH,
    WEST,
    EAST
  } port_t;

endpackage

// File: rtl/round_robin_arbiter.sv
// N-way round-robin arbiter; one-hot grant plus grant index.
// The pointer moves past the winner only when update_en is set.
module round_robin_arbiter #(
  parameter  int N = 4,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] request,
  input  logic         update_en,
  output logic [N-1:0] grant,
  output logic [W-1:0] grant_idx
);

  logic [W-1:0] ptr;
  logic [W-1:0] nxt_ptr;

  // Scan from the farthest offset down so the nearest request wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    nxt_ptr   = ptr;
    for (int i = N - 1; i >= 0; i--) begin
      if (request[(int'(ptr) + i) % N]) begin
        grant     = '0;
        grant[(int'(ptr) + i) % N] = 1'b1;
        grant_idx = W'((int'(ptr) + i) % N);
        nxt_ptr   = W'((int'(ptr) + i + 1) % N);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else if (update_en) begin
      ptr <= nxt_ptr;
    end
  end

endmodule

// File: rtl/switch_allocator.sv
// Separable input-first round-robin switch allocator.
// Grants are registered and drive input ports and crossbar.
module switch_allocator
  import noc_params::*;
(
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic  [PORT_NUM-1:0][VC_NUM-1:0]           request_i,
  input  port_t [PORT_NUM-1:0][VC_NUM-1:0]           out_port_i,
  input  logic  [PORT_NUM-1:0][VC_NUM-1:0][VC_SIZE-1:0] downstream_vc_i,
  input  logic  [PORT_NUM-1:0][VC_NUM-1:0]           on_off_i,
  output logic  [PORT_NUM-1:0]                       valid_sel_o,
  output logic  [PORT_NUM-1:0][VC_SIZE-1:0]          vc_sel_o,
  output logic  [PORT_NUM-1:0]                       xbar_valid_o,
  output logic  [PORT_NUM-1:0][PORT_SIZE-1:0]        xbar_sel_o
);

  logic  [PORT_NUM-1:0][VC_NUM-1:0]    elig;
  logic  [PORT_NUM-1:0][VC_NUM-1:0]    vc_gnt;
  logic  [PORT_NUM-1:0][VC_SIZE-1:0]   win_vc;
  logic  [PORT_NUM-1:0]                in_req;
  logic  [PORT_NUM-1:0]                in_win;
  port_t [PORT_NUM-1:0]                tgt;
  logic  [PORT_NUM-1:0][PORT_NUM-1:0]  s2_req;
  logic  [PORT_NUM-1:0][PORT_NUM-1:0]  s2_gnt;
  logic  [PORT_NUM-1:0][PORT_SIZE-1:0] s2_win;

  always_comb begin
    elig = '0;
    for (int p = 0; p < PORT_NUM; p++) begin
      for (int v = 0; v < VC_NUM; v++) begin
        elig[p][v] = request_i[p][v] &
          on_off_i[out_port_i[p][v]][downstream_vc_i[p][v]];
      end
    end
  end

  for (genvar p = 0; p < PORT_NUM; p++) begin : g_in
    round_robin_arbiter #(.N(VC_NUM)) u_arb (
      .clk       (clk),
      .rst       (rst),
      .request   (elig[p]),
      .update_en (in_win[p]),
      .grant     (vc_gnt[p]),
      .grant_idx (win_vc[p])
    );
    assign in_req[p] = |vc_gnt[p];
    assign tgt[p]    = out_port_i[p][win_vc[p]];
  end

  // s2_req/s2_gnt are indexed [output][input].
  always_comb begin
    s2_req = '0;
    for (int o = 0; o < PORT_NUM; o++) begin
      for (int p = 0; p < PORT_NUM; p++) begin
        s2_req[o][p] = in_req[p] && (int'(tgt[p]) == o);
      end
    end
  end

  for (genvar o = 0; o < PORT_NUM; o++) begin : g_out
    round_robin_arbiter #(.N(PORT_NUM)) u_arb (
      .clk       (clk),
      .rst       (rst),
      .request   (s2_req[o]),
      .update_en (|s2_req[o]),
      .grant     (s2_gnt[o]),
      .grant_idx (s2_win[o])
    );
  end

  always_comb begin
    in_win = '0;
    for (int o = 0; o < PORT_NUM; o++) begin
      for (int p = 0; p < PORT_NUM; p++) begin
        in_win[p] = in_win[p] | s2_gnt[o][p];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_sel_o  <= '0;
      vc_sel_o     <= '0;
      xbar_valid_o <= '0;
      xbar_sel_o   <= '0;
    end else begin
      valid_sel_o <= in_win;
      for (int p = 0; p < PORT_NUM; p++) begin
        if (in_win[p]) vc_sel_o[p] <= win_vc[p];
      end
      for (int o = 0; o < PORT_NUM; o++) begin
        xbar_valid_o[o] <= |s2_req[o];
        if (|s2_req[o]) xbar_sel_o[o] <= s2_win[o];
      end
    end
  end

endmodule

// File: tb/tb_switch_allocator.sv
// Self-checking bench: behavioural allocator model plus
// directed scenarios with literal expectations.
module tb_switch_allocator;
  import noc_params::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic  [PORT_NUM-1:0][VC_NUM-1:0]              request;
  port_t [PORT_NUM-1:0][VC_NUM-1:0]              out_port;
  logic  [PORT_NUM-1:0][VC_NUM-1:0][VC_SIZE-1:0] ds_vc;
  logic  [PORT_NUM-1:0][VC_NUM-1:0]              on_off;
  logic  [PORT_NUM-1:0]                          valid_sel;
  logic  [PORT_NUM-1:0][VC_SIZE-1:0]             vc_sel;
  logic  [PORT_NUM-1:0]                          xbar_valid;
  logic  [PORT_NUM-1:0][PORT_SIZE-1:0]           xbar_sel;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  switch_allocator dut (
    .clk             (clk),
    .rst             (rst),
    .request_i       (request),
    .out_port_i      (out_port),
    .downstream_vc_i (ds_vc),
    .on_off_i        (on_off),
    .valid_sel_o     (valid_sel),
    .vc_sel_o        (vc_sel),
    .xbar_valid_o    (xbar_valid),
    .xbar_sel_o      (xbar_sel)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int s1p[PORT_NUM];
    int s2p[PORT_NUM];
    int vs[PORT_NUM];
    int vc[PORT_NUM];
    int xv[PORT_NUM];
    int xs[PORT_NUM];
  } model_t;

  model_t mdl;

  function automatic model_t model_zero();
    model_t m;
    for (int i = 0; i < PORT_NUM; i++) begin
      m.s1p[i] = 0; m.s2p[i] = 0; m.vs[i] = 0;
      m.vc[i]  = 0; m.xv[i]  = 0; m.xs[i] = 0;
    end
    return m;
  endfunction

  // Each input offers its first eligible VC from its pointer; each
  // output takes the first offering input from its pointer.
  function automatic model_t model_step(input model_t m);
    model_t n = m;
    int  win[PORT_NUM];
    bit  has[PORT_NUM];
    for (int p = 0; p < PORT_NUM; p++) begin
      has[p] = 0; win[p] = 0;
      for (int k = 0; k < VC_NUM; k++) begin
        int v = (m.s1p[p] + k) % VC_NUM;
        if (!has[p] && request[p][v] &&
            on_off[int'(out_port[p][v])][int'(ds_vc[p][v])]) begin
          has[p] = 1; win[p] = v;
        end
      end
      n.vs[p] = 0;
    end
    for (int o = 0; o < PORT_NUM; o++) begin
      bit found = 0;
      for (int k = 0; k < PORT_NUM; k++) begin
        int p = (m.s2p[o] + k) % PORT_NUM;
        if (!found && has[p] && int'(out_port[p][win[p]]) == o) begin
          found = 1;
          n.vs[p] = 1; n.vc[p] = win[p];
          n.s1p[p] = (win[p] + 1) % VC_NUM;
          n.s2p[o] = (p + 1) % PORT_NUM;
          n.xs[o] = p;
        end
      end
      n.xv[o] = found ? 1 : 0;
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) mdl <= model_zero();
    else      mdl <= model_step(mdl);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < PORT_NUM; i++) begin
        chk($sformatf("model valid_sel[%0d]", i), int'(valid_sel[i]), mdl.vs[i]);
        chk($sformatf("model vc_sel[%0d]", i), int'(vc_sel[i]), mdl.vc[i]);
        chk($sformatf("model xbar_valid[%0d]", i), int'(xbar_valid[i]), mdl.xv[i]);
        chk($sformatf("model xbar_sel[%0d]", i), int'(xbar_sel[i]), mdl.xs[i]);
      end
    end
  end

  task automatic clear_inputs();
    request = '0;
    ds_vc   = '0;
    on_off  = '1;
    for (int p = 0; p < PORT_NUM; p++)
      for (int v = 0; v < VC_NUM; v++) out_port[p][v] = LOCAL;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic post_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clear_inputs();
    #1 rst = 1'b0;
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Idle after reset
    for (int i = 0; i < 5; i++) begin
      post_edge();
      chk("idle valid_sel", int'(valid_sel), 0);
      chk("idle xbar_valid", int'(xbar_valid), 0);
    end

    // Single flit: NORTH VC0 -> EAST, downstream VC1
    @(negedge clk);
    request[1][0] = 1'b1; out_port[1][0] = EAST; ds_vc[1][0] = 1'b1;
    post_edge();
    chk("single valid_sel[1]", int'(valid_sel[1]), 1);
    chk("single vc_sel[1]", int'(vc_sel[1]), 0);
    chk("single xbar_valid[4]", int'(xbar_valid[4]), 1);
    chk("single xbar_sel[4]", int'(xbar_sel[4]), 1);
    @(negedge clk);
    request = '0;
    post_edge();
    chk("drain valid_sel", int'(valid_sel), 0);

    // Output contention on EAST from inputs 0,1,2
    do_reset();
    for (int p = 0; p < 3; p++) begin
      request[p][0] = 1'b1; out_port[p][0] = EAST;
    end
    for (int i = 0; i < 6; i++) begin
      post_edge();
      chk("contend xbar_sel[4]", int'(xbar_sel[4]), i % 3);
      chk("contend one input", $countones(valid_sel), 1);
    end

    // Async reset in the middle of contention
    #2 rst = 1'b0;
    #1;
    chk("async valid_sel", int'(valid_sel), 0);
    chk("async xbar_valid", int'(xbar_valid), 0);
    chk("async xbar_sel", int'(xbar_sel), 0);
    @(negedge clk);
    rst = 1'b1;
    post_edge();
    chk("post-reset xbar_sel[4]", int'(xbar_sel[4]), 0);
    chk("post-reset valid_sel", int'(valid_sel), 1);

    // VC rotation on input 3 with uncontended outputs
    do_reset();
    request[3] = 2'b11;
    out_port[3][0] = NORTH; out_port[3][1] = SOUTH;
    for (int i = 0; i < 4; i++) begin
      post_edge();
      chk("rotate vc_sel[3]", int'(vc_sel[3]), i % 2);
      chk("rotate valid_sel[3]", int'(valid_sel[3]), 1);
    end

    // Flow control masks EAST VC1
    do_reset();
    on_off[4][1] = 1'b0;
    request[1][0] = 1'b1; out_port[1][0] = EAST; ds_vc[1][0] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      post_edge();
      chk("blocked valid_sel[1]", int'(valid_sel[1]), 0);
      chk("blocked xbar_valid[4]", int'(xbar_valid[4]), 0);
    end
    @(negedge clk);
    on_off[4][1] = 1'b1;
    post_edge();
    chk("unblocked valid_sel[1]", int'(valid_sel[1]), 1);
    chk("unblocked xbar_sel[4]", int'(xbar_sel[4]), 1);

    // Mixed traffic, checked by the model only
    do_reset();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      for (int p = 0; p < PORT_NUM; p++) begin
        for (int v = 0; v < VC_NUM; v++) begin
          request[p][v]  = ($urandom_range(0, 3) != 0);
          out_port[p][v] = port_t'($urandom_range(0, PORT_NUM - 1));
          ds_vc[p][v]    = VC_SIZE'($urandom_range(0, VC_NUM - 1));
          on_off[p][v]   = ($urandom_range(0, 4) != 0);
        end
      end
    end
    @(negedge clk);
    clear_inputs();
    repeat (3) @(negedge clk);
    chk_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
